// File: rtl/branch_counter_bank.sv
// Bank of 2-bit saturating branch counters trained by one-hot demux updates,
// with registered lookups, same-edge update bypass and synchronous flush.
module branch_counter_bank #(
    parameter int         ENTRIES    = 16,
    parameter int         IDX_W      = 4,
    parameter logic [1:0] INIT_STATE = 2'b01
) (
    input  logic               CLK,
    input  logic               RESETN,
    input  logic [ENTRIES-1:0] UPD_EN,
    input  logic [ENTRIES-1:0] UPD_OUTCOME,
    input  logic               FLUSH,
    input  logic               PRED_REQ,
    input  logic [IDX_W-1:0]   PRED_INDEX,
    output logic               PRED_VALID,
    output logic               PREDICTION,
    output logic [1:0]         PRED_STATE,
    output logic               UPD_ERR
);

    logic [ENTRIES-1:0][1:0] ctr;
    logic [ENTRIES-1:0][1:0] ctr_nxt;
    logic                    multi_hot;
    logic [1:0]              lookup;

    // More than one enable bit set: clearing the lowest set bit leaves something.
    assign multi_hot = |(UPD_EN & (UPD_EN - ENTRIES'(1)));

    // Next counter values: flush wins, multi-hot is dropped, else saturate.
    always_comb begin
        ctr_nxt = ctr;
        for (int i = 0; i < ENTRIES; i++) begin
            if (FLUSH) begin
                ctr_nxt[i] = INIT_STATE;
            end else if (UPD_EN[i] && !multi_hot) begin
                if (UPD_OUTCOME[i]) begin
                    if (ctr[i] != 2'b11) ctr_nxt[i] = ctr[i] + 2'b01;
                end else begin
                    if (ctr[i] != 2'b00) ctr_nxt[i] = ctr[i] - 2'b01;
                end
            end
        end
    end

    // Lookup reads post-update values so a same-edge update is bypassed;
    // indices with no matching entry fall through to 00.
    always_comb begin
        lookup = 2'b00;
        for (int i = 0; i < ENTRIES; i++) begin
            if (PRED_INDEX == IDX_W'(i)) lookup = ctr_nxt[i];
        end
    end

    // Counter storage.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= INIT_STATE;
        end else begin
            ctr <= ctr_nxt;
        end
    end

    // Registered lookup result and error pulse; result holds when idle.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            PRED_VALID <= 1'b0;
            PREDICTION <= 1'b0;
            PRED_STATE <= 2'b00;
            UPD_ERR    <= 1'b0;
        end else begin
            PRED_VALID <= PRED_REQ;
            UPD_ERR    <= multi_hot;
            if (PRED_REQ) begin
                PRED_STATE <= lookup;
                PREDICTION <= lookup[1];
            end
        end
    end

endmodule

// File: doc/branch_counter_bank.md
Name: branch_counter_bank

Overview:
- Bank of per-entry 2-bit saturating branch-history counters.
- Sits directly downstream of the 4-bit-column outcome demultiplexer.
- Consumes its one-hot enable/outcome pairs to train the selected counter, and answers registered prediction lookups from the fetch stage.
- Provides a same-cycle update-to-lookup bypass and a synchronous flush for pipeline/context resets.

Parameters:
- ENTRIES, 16, number of counters; equals the demultiplexer fan-out.
- IDX_W, 4, lookup index width; log2(ENTRIES).
- INIT_STATE, 2'b01, counter value after reset or flush (weakly not-taken).

Ports:
- CLK  input  1  rising-edge clock.
- RESETN  input  1  asynchronous active-low reset.
- UPD_EN  input  ENTRIES  per-entry update enables (demux enable0..enable15); expected one-hot or zero.
- UPD_OUTCOME  input  ENTRIES  per-entry resolved outcome (demux out0..out15); 1 = taken.
- FLUSH  input  1  synchronous reinitialise of all counters.
- PRED_REQ  input  1  lookup request.
- PRED_INDEX  input  IDX_W  entry to look up.
- PRED_VALID  output  1  lookup result valid.
- PREDICTION  output  1  predicted direction; counter MSB.
- PRED_STATE  output  2  full counter value of the looked-up entry.
- UPD_ERR  output  1  one-cycle pulse: illegal multi-hot UPD_EN was rejected.

Behaviour:
- Reset (RESETN low, asynchronous):
  - All counters = INIT_STATE.
  - PRED_VALID = 0, PREDICTION = 0, PRED_STATE = 2'b00, UPD_ERR = 0.
  - Release is synchronous to the next CLK edge. Reset asserted mid-operation discards any in-flight lookup.
- Counter encoding and transitions (per entry, evaluated at the rising edge):
  - 00 strongly-not-taken, 01 weakly-not-taken, 10 weakly-taken, 11 strongly-taken.
  - Taken: increment, saturating at 11.
  - Not-taken: decrement, saturating at 00.
  - No wrap-around in either direction.
- Update:
  - UPD_EN zero: no counter changes.
  - UPD_EN exactly one bit k set: counter k updates using UPD_OUTCOME[k]. UPD_OUTCOME bits of unselected entries are ignored.
  - UPD_EN with two or more bits set: no counter changes; UPD_ERR = 1 on the following cycle only.
- Flush:
  - FLUSH = 1 sets every counter to INIT_STATE at the edge.
  - FLUSH overrides a simultaneous update. UPD_ERR still reports a multi-hot UPD_EN.
- Lookup latency and handshake:
  - Fixed latency of 1 cycle: PRED_REQ and PRED_INDEX sampled at edge N; PRED_VALID = 1 during cycle N+1 with PREDICTION and PRED_STATE.
  - PRED_REQ = 0 at edge N: PRED_VALID = 0 in cycle N+1. PREDICTION and PRED_STATE hold their last values.
  - Back-to-back requests are accepted every cycle. No stall or backpressure.
- Bypass:
  - Lookup and legal update to the same index at the same edge: the result reflects the post-update value.
  - Lookup and flush at the same edge: the result is INIT_STATE.
  - Lookup and rejected multi-hot update: the result is the unchanged counter.
- PRED_INDEX ≥ ENTRIES (only possible when ENTRIES < 2^IDX_W): PRED_VALID = 1, PREDICTION = 0, PRED_STATE = 00.
- All outputs are registered. There is no combinational path from inputs to outputs.

Test Plan:
- Reset default: RESETN low 2 cycles, release, PRED_REQ with index 5 → next cycle PRED_VALID = 1, PRED_STATE = 01, PREDICTION = 0.
- Saturation up: UPD_EN = 16'h0008, UPD_OUTCOME[3] = 1 for 4 consecutive edges, then look up index 3 → PRED_STATE = 11, PREDICTION = 1. Repeat with outcome 0 for 5 edges → PRED_STATE = 00.
- Bypass: entry 7 at 01; same edge UPD_EN = 16'h0080 with taken, PRED_REQ with index 7 → next cycle PRED_STATE = 10, PREDICTION = 1.
- Multi-hot reject: UPD_EN = 16'h0011, all outcomes 1 → UPD_ERR = 1 for exactly one cycle; entries 0 and 4 remain 01.
- Flush priority: entry 2 at 11; FLUSH = 1 together with a taken update to entry 2 and a lookup of entry 2 → lookup returns 01; subsequent lookup of any entry returns 01.
- Async reset mid-stream: assert RESETN low between edges while a lookup is in flight → PRED_VALID drops to 0 immediately, no valid result after release, and all counters read 01.
